// File: rtl/mem_dados_io.sv
// Data-memory stage for the nRisc load/store path: 240-byte RAM, a small
// memory-mapped I/O page (LEDs, switches, timer) and programmable wait states.
module mem_dados_io #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  IO_BASE     = 8'hF0
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [7:0] Endereco,
  input  logic [7:0] DadoEscr,
  input  logic       LerMem,
  input  logic       EscrevMem,
  output logic [7:0] DadoLido,
  output logic       MemPronto,
  input  logic [7:0] Chaves,
  output logic [7:0] Leds
);

  localparam int unsigned RAM_DEPTH  = 32'(IO_BASE);
  localparam logic [7:0]  A_LEDS     = IO_BASE;
  localparam logic [7:0]  A_CHAVES   = IO_BASE + 8'd1;
  localparam logic [7:0]  A_TIMER    = IO_BASE + 8'd2;
  localparam logic [7:0]  A_CLR      = IO_BASE + 8'd3;
  localparam logic        SEM_ESPERA = (WAIT_STATES == 0);
  localparam logic [3:0]  CNT_INI    = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ESPERA = 2'd1,
    PRONTO = 2'd2
  } estado_t;

  estado_t    estado;
  logic [3:0] cnt;
  logic [7:0] end_q;
  logic [7:0] dado_q;
  logic       escr_q;
  logic [7:0] timer_cap;
  logic [7:0] timer;
  logic [7:0] chv_meta;
  logic [7:0] chv_sync;
  logic [7:0] ram [RAM_DEPTH];

  logic       req_c;
  logic       commit_c;
  logic [7:0] end_c;
  logic [7:0] dado_c;
  logic       escr_c;
  logic [7:0] tcap_c;
  logic [7:0] rd_c;

  always_ff @(posedge Clock) begin
    assert (WAIT_STATES <= 32'd15)
      else $error("mem_dados_io: WAIT_STATES=%0d exceeds the 4-bit wait counter", WAIT_STATES);
  end

  // With zero wait states the access commits on its own sample edge, so the
  // live request fields are used; otherwise the values latched at sampling.
  always_comb begin
    req_c    = LerMem | EscrevMem;
    end_c    = end_q;
    dado_c   = dado_q;
    escr_c   = escr_q;
    tcap_c   = timer_cap;
    commit_c = 1'b0;
    if (estado == OCIOSO) begin
      end_c    = Endereco;
      dado_c   = DadoEscr;
      escr_c   = EscrevMem;
      tcap_c   = timer;
      commit_c = req_c & SEM_ESPERA;
    end else if (estado == ESPERA) begin
      commit_c = (cnt == 4'd0);
    end
  end

  // Read data mux for the committing access.
  always_comb begin
    rd_c = 8'h00;
    if (end_c < IO_BASE) begin
      rd_c = ram[end_c];
    end else begin
      case (end_c)
        A_LEDS:   rd_c = Leds;
        A_CHAVES: rd_c = chv_sync;
        A_TIMER:  rd_c = tcap_c;
        default:  rd_c = 8'h00;
      endcase
    end
  end

  // RAM is never cleared; reset only suppresses an in-flight store.
  always_ff @(posedge Clock) begin
    if (Reset_n && commit_c && escr_c && (end_c < IO_BASE)) begin
      ram[end_c] <= dado_c;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      estado    <= OCIOSO;
      cnt       <= 4'd0;
      end_q     <= 8'h00;
      dado_q    <= 8'h00;
      escr_q    <= 1'b0;
      timer_cap <= 8'h00;
      timer     <= 8'h00;
      chv_meta  <= 8'h00;
      chv_sync  <= 8'h00;
      DadoLido  <= 8'h00;
      MemPronto <= 1'b0;
      Leds      <= 8'h00;
    end else begin
      chv_meta  <= Chaves;
      chv_sync  <= chv_meta;
      MemPronto <= commit_c;

      // Clear wins over the free-running increment.
      if (commit_c && escr_c && (end_c == A_CLR)) begin
        timer <= 8'h00;
      end else begin
        timer <= timer + 8'd1;
      end

      if (commit_c) begin
        if (escr_c) begin
          if (end_c == A_LEDS) begin
            Leds <= dado_c;
          end
        end else begin
          DadoLido <= rd_c;
        end
      end

      case (estado)
        OCIOSO: begin
          if (req_c) begin
            end_q     <= Endereco;
            dado_q    <= DadoEscr;
            escr_q    <= EscrevMem;
            timer_cap <= timer;
            if (SEM_ESPERA) begin
              estado <= PRONTO;
            end else begin
              estado <= ESPERA;
              cnt    <= CNT_INI;
            end
          end
        end
        ESPERA: begin
          if (cnt == 4'd0) begin
            estado <= PRONTO;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PRONTO:  estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dados_io.sv
// Bench for mem_dados_io: one instance with one wait state, one with none,
// checked against an address-map/timer model kept in plain arrays and edge counts.
module tb_mem_dados_io;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ler    [2];
  logic       esc    [2];
  logic [7:0] ender  [2];
  logic [7:0] dado   [2];
  logic [7:0] lido   [2];
  logic       pronto [2];
  logic [7:0] leds   [2];
  logic [7:0] chaves;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;
  int          ws [2] = '{1, 0};

  // Reference model: RAM image, LED register, last load result, and the
  // edge index at which each timer was last zeroed.
  logic [7:0] m_ram  [2][256];
  logic [7:0] m_leds [2];
  logic [7:0] m_last [2];
  int         m_z    [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_dados_io #(.WAIT_STATES(1), .IO_BASE(8'hF0)) u_dut1 (
    .Clock(clk), .Reset_n(rst_n), .Endereco(ender[0]), .DadoEscr(dado[0]),
    .LerMem(ler[0]), .EscrevMem(esc[0]), .DadoLido(lido[0]), .MemPronto(pronto[0]),
    .Chaves(chaves), .Leds(leds[0])
  );

  mem_dados_io #(.WAIT_STATES(0), .IO_BASE(8'hF0)) u_dut0 (
    .Clock(clk), .Reset_n(rst_n), .Endereco(ender[1]), .DadoEscr(dado[1]),
    .LerMem(ler[1]), .EscrevMem(esc[1]), .DadoLido(lido[1]), .MemPronto(pronto[1]),
    .Chaves(chaves), .Leds(leds[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Holds reset for two edges; MemPronto must stay low throughout.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ler[i] = 1'b0;
      esc[i] = 1'b0;
    end
    repeat (2) begin
      @(posedge clk); #1;
      chk("pronto_reset0", pronto[0], 0);
      chk("pronto_reset1", pronto[1], 0);
    end
    for (int i = 0; i < 2; i++) begin
      m_z[i]    = cyc;
      m_leds[i] = 8'h00;
      m_last[i] = 8'h00;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete access; chv < 0 picks random switches, held 3 cycles first.
  task automatic do_acc(input int sel, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d, input int chv);
    int         s;
    int         k;
    logic       got;
    logic [7:0] v;
    @(negedge clk);
    chaves = (chv < 0) ? 8'($urandom) : 8'(chv);
    repeat (3) @(negedge clk);
    ler[sel]   = rd;
    esc[sel]   = wr;
    ender[sel] = a;
    dado[sel]  = d;
    @(posedge clk); #1;
    s   = cyc;
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      if (pronto[sel]) begin
        got = 1'b1;
      end else begin
        ler[sel]   = 1'($urandom);
        esc[sel]   = 1'($urandom);
        ender[sel] = 8'($urandom);
        dado[sel]  = 8'($urandom);
        @(posedge clk); #1;
        k++;
      end
    end
    if (!got) chk("timeout_pronto", 0, 1);
    else      chk("latencia", k, ws[sel]);

    if (wr) begin
      if (a < 8'hF0)       m_ram[sel][a] = d;
      else if (a == 8'hF0) m_leds[sel]   = d;
      else if (a == 8'hF3) m_z[sel]      = s + ws[sel];
    end else begin
      if (a < 8'hF0) begin
        v = m_ram[sel][a];
      end else begin
        case (a)
          8'hF0:   v = m_leds[sel];
          8'hF1:   v = chaves;
          8'hF2:   v = 8'(s - 1 - m_z[sel]);
          default: v = 8'h00;
        endcase
      end
      m_last[sel] = v;
    end
    chk($sformatf("dado_lido[%0d]@%02h", sel, a), lido[sel], m_last[sel]);
    chk($sformatf("leds[%0d]", sel), leds[sel], m_leds[sel]);

    ler[sel] = 1'b0;
    esc[sel] = 1'b0;
    @(posedge clk); #1;
    chk("pulso_unico", pronto[sel], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    logic       r;
    logic       w;
    int         op;
    int         sel;
    chaves = 8'h00;
    for (int i = 0; i < 2; i++) begin
      ler[i]   = 1'b0;
      esc[i]   = 1'b0;
      ender[i] = 8'h00;
      dado[i]  = 8'h00;
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      chk("reset_dado_lido", lido[i], 0);
      chk("reset_pronto", pronto[i], 0);
      chk("reset_leds", leds[i], 0);
    end

    do_acc(0, 1'b1, 1'b0, 8'hF2, 8'h00, -1);
    do_acc(0, 1'b0, 1'b1, 8'h10, 8'h5A, -1);
    do_acc(0, 1'b1, 1'b0, 8'h10, 8'h00, -1);
    do_acc(0, 1'b0, 1'b1, 8'hF0, 8'hC3, -1);
    do_acc(0, 1'b1, 1'b0, 8'hF1, 8'h00, 8'h81);
    do_acc(0, 1'b1, 1'b0, 8'hF0, 8'h00, -1);

    repeat (300) @(negedge clk);
    do_acc(0, 1'b1, 1'b0, 8'hF2, 8'h00, -1);
    do_acc(0, 1'b0, 1'b1, 8'hF3, 8'hA5, -1);
    repeat (5) @(negedge clk);
    do_acc(0, 1'b1, 1'b0, 8'hF2, 8'h00, -1);

    do_acc(0, 1'b1, 1'b0, 8'h10, 8'h00, -1);
    do_acc(0, 1'b1, 1'b1, 8'h20, 8'h77, -1);
    do_acc(0, 1'b1, 1'b0, 8'h20, 8'h00, -1);
    do_acc(0, 1'b1, 1'b0, 8'hF5, 8'h00, -1);
    do_acc(0, 1'b0, 1'b1, 8'hF1, 8'hEE, -1);
    do_acc(0, 1'b0, 1'b1, 8'hF2, 8'hEE, -1);

    // Reset while the store is waiting: it must never commit.
    do_acc(0, 1'b0, 1'b1, 8'h30, 8'h11, -1);
    @(negedge clk);
    esc[0]   = 1'b1;
    ender[0] = 8'h30;
    dado[0]  = 8'h99;
    @(posedge clk); #1;
    chk("aborto_espera", pronto[0], 0);
    do_reset();
    chk("aborto_leds", leds[0], 0);
    do_acc(0, 1'b1, 1'b0, 8'h30, 8'h00, -1);

    do_acc(1, 1'b0, 1'b1, 8'h44, 8'h3C, -1);
    do_acc(1, 1'b1, 1'b0, 8'h44, 8'h00, -1);
    do_acc(1, 1'b1, 1'b0, 8'hF2, 8'h00, -1);

    for (int s2 = 0; s2 < 2; s2++) begin
      for (int i = 0; i < 16; i++) begin
        do_acc(s2, 1'b0, 1'b1, 8'(i), 8'($urandom), -1);
      end
    end

    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 1));
      op  = int'($urandom_range(0, 2));
      r   = (op != 1);
      w   = (op != 0);
      if ($urandom_range(0, 9) < 6) a = 8'($urandom_range(0, 15));
      else                          a = 8'($urandom_range(8'hF0, 8'hFF));
      do_acc(sel, r, w, a, 8'($urandom), -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
